// File: rtl/alu_op_sequencer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer_pkg
//  Description : Shared ALU opcodes, sequencer state encoding and the
//                opcode legality screen.
//  Revision    : 1.0 - initial release
// ============================================================================
package alu_op_sequencer_pkg;

    localparam logic [3:0] c_ALU_AND   = 4'b0000;
    localparam logic [3:0] c_ALU_OR    = 4'b0001;
    localparam logic [3:0] c_ALU_ADD   = 4'b0010;
    localparam logic [3:0] c_ALU_LSL   = 4'b0011;
    localparam logic [3:0] c_ALU_LSR   = 4'b0100;
    localparam logic [3:0] c_ALU_SUB   = 4'b0110;
    localparam logic [3:0] c_ALU_PASSB = 4'b0111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } seq_state_t;

    function automatic logic alu_ctrl_legal(input logic [3:0] ctrl);
        case (ctrl)
            c_ALU_AND, c_ALU_OR, c_ALU_ADD, c_ALU_LSL,
            c_ALU_LSR, c_ALU_SUB, c_ALU_PASSB: alu_ctrl_legal = 1'b1;
            default:                           alu_ctrl_legal = 1'b0;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : alu_op_sequencer
//  Description : Issues one request at a time to a combinational ALU, holds
//                its inputs for RESULT_LATENCY cycles, then returns the result.
//  Revision    : 1.0 - initial release
// ============================================================================
module alu_op_sequencer
    import alu_op_sequencer_pkg::*;
#(
    parameter int N              = 64,
    parameter int RESULT_LATENCY = 3,
    parameter int COUNT_WIDTH    = 32
) (
    input  logic                   CLK,
    input  logic                   Reset,
    input  logic                   ReqValid,
    output logic                   ReqReady,
    input  logic [N-1:0]           ReqA,
    input  logic [N-1:0]           ReqB,
    input  logic [3:0]             ReqCtrl,
    output logic [N-1:0]           AluBusA,
    output logic [N-1:0]           AluBusB,
    output logic [3:0]             AluCtrl,
    input  logic [N-1:0]           AluBusW,
    input  logic                   AluZero,
    output logic                   RespValid,
    input  logic                   RespReady,
    output logic [N-1:0]           RespData,
    output logic                   RespZero,
    output logic                   RespErr,
    output logic [COUNT_WIDTH-1:0] OpCount
);

    localparam logic [3:0] c_CNT_LOAD = 4'(RESULT_LATENCY - 1);

    seq_state_t             r_state,     w_state_nxt;
    logic [3:0]             r_cnt,       w_cnt_nxt;
    logic [N-1:0]           r_alu_a,     w_alu_a_nxt;
    logic [N-1:0]           r_alu_b,     w_alu_b_nxt;
    logic [3:0]             r_alu_ctrl,  w_alu_ctrl_nxt;
    logic [N-1:0]           r_resp_data, w_resp_data_nxt;
    logic                   r_resp_zero, w_resp_zero_nxt;
    logic                   r_resp_err,  w_resp_err_nxt;
    logic [COUNT_WIDTH-1:0] r_op_count,  w_op_count_nxt;

    // Handshakes are masked while Reset is high so reset wins over both streams.
    logic w_req_ready;
    logic w_resp_valid;
    assign w_req_ready  = (r_state == ST_IDLE) && !Reset;
    assign w_resp_valid = (r_state == ST_RESP) && !Reset;

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_alu_a_nxt     = r_alu_a;
        w_alu_b_nxt     = r_alu_b;
        w_alu_ctrl_nxt  = r_alu_ctrl;
        w_resp_data_nxt = r_resp_data;
        w_resp_zero_nxt = r_resp_zero;
        w_resp_err_nxt  = r_resp_err;
        w_op_count_nxt  = r_op_count;

        case (r_state)
            ST_IDLE: begin
                if (ReqValid && w_req_ready) begin
                    if (alu_ctrl_legal(ReqCtrl)) begin
                        w_alu_a_nxt    = ReqA;
                        w_alu_b_nxt    = ReqB;
                        w_alu_ctrl_nxt = ReqCtrl;
                        w_cnt_nxt      = c_CNT_LOAD;
                        w_state_nxt    = ST_EXEC;
                    end else begin
                        // Illegal opcodes never reach the ALU; answer with an error.
                        w_resp_data_nxt = '0;
                        w_resp_zero_nxt = 1'b1;
                        w_resp_err_nxt  = 1'b1;
                        w_state_nxt     = ST_RESP;
                    end
                end
            end
            ST_EXEC: begin
                if (r_cnt == 4'd0) begin
                    w_resp_data_nxt = AluBusW;
                    w_resp_zero_nxt = AluZero;
                    w_resp_err_nxt  = 1'b0;
                    w_state_nxt     = ST_RESP;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ST_RESP: begin
                if (RespReady && w_resp_valid) begin
                    w_op_count_nxt = r_op_count + 1'b1;
                    w_state_nxt    = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_ctrl  <= '0;
            r_resp_data <= '0;
            r_resp_zero <= 1'b0;
            r_resp_err  <= 1'b0;
            r_op_count  <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_alu_a     <= w_alu_a_nxt;
            r_alu_b     <= w_alu_b_nxt;
            r_alu_ctrl  <= w_alu_ctrl_nxt;
            r_resp_data <= w_resp_data_nxt;
            r_resp_zero <= w_resp_zero_nxt;
            r_resp_err  <= w_resp_err_nxt;
            r_op_count  <= w_op_count_nxt;
        end
    end

    assign ReqReady  = w_req_ready;
    assign RespValid = w_resp_valid;
    assign AluBusA   = r_alu_a;
    assign AluBusB   = r_alu_b;
    assign AluCtrl   = r_alu_ctrl;
    assign RespData  = r_resp_data;
    assign RespZero  = r_resp_zero;
    assign RespErr   = r_resp_err;
    assign OpCount   = r_op_count;

endmodule
`default_nettype wire
